// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Free-running h/v counters advanced on the pixel
// tick, combinational position/request outputs, and a timing delay line that
// re-aligns sync and data enable with RGB returned by a pipelined pixel source.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE_LAT = 1,
    parameter int CNT_W    = 10,
    parameter int COLOR_W  = 4
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               en_i,
    input  logic [COLOR_W-1:0] red_i,
    input  logic [COLOR_W-1:0] green_i,
    input  logic [COLOR_W-1:0] blue_i,
    output logic               req_o,
    output logic [CNT_W-1:0]   x_o,
    output logic [CNT_W-1:0]   y_o,
    output logic               line_start_o,
    output logic               frame_start_o,
    output logic [COLOR_W-1:0] red_o,
    output logic [COLOR_W-1:0] green_o,
    output logic [COLOR_W-1:0] blue_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync bounds carry one extra bit so an end bound equal to 2**CNT_W still compares correctly.
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W:0]   HS_BEG   = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0]   HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   VS_BEG   = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0]   VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    // Timing flags carried down the delay line; all-zero is the blanking state.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } timing_t;

    // Illegal parameter sets stop elaboration.
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_err_width
        $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end
    if (H_SYNC < 1 || V_SYNC < 1) begin : g_err_sync
        $error("vga_timing_gen: sync widths must be non-zero");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_err_lat
        $error("vga_timing_gen: PIPE_LAT must be 0..7");
    end

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    timing_t          w_raw;
    timing_t          w_del;
    logic             r_de;
    logic             r_hs;
    logic             r_vs;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;

    // Raster counters: h wraps every H_TOTAL ticks, v advances on each h wrap.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_ni) begin
            r_h <= '0;
            r_v <= '0;
        end else if (en_i) begin
            if (r_h == H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? '0 : r_v + CNT_W'(1);
            end else begin
                r_h <= r_h + CNT_W'(1);
            end
        end
    end

    assign x_o           = r_h;
    assign y_o           = r_v;
    assign req_o         = (r_h < H_ACT_C) && (r_v < V_ACT_C);
    assign line_start_o  = en_i && (r_h == '0);
    assign frame_start_o = en_i && (r_h == '0) && (r_v == '0);

    assign w_raw.de = req_o;
    assign w_raw.hs = ({1'b0, r_h} >= HS_BEG) && ({1'b0, r_h} < HS_END);
    assign w_raw.vs = ({1'b0, r_v} >= VS_BEG) && ({1'b0, r_v} < VS_END);

    if (PIPE_LAT > 0) begin : g_pipe
        timing_t r_pipe [PIPE_LAT];

        // Delay line matching the pixel source latency, advanced on the pixel tick.
        always_ff @(posedge clk_i or negedge reset_ni) begin
            // NOTE: this small delay line is reset on purpose so no stale sync/de leaks out after reset.
            if (!reset_ni) begin
                for (int i = 0; i < PIPE_LAT; i++) begin
                    r_pipe[i] <= '0;
                end
            end else if (en_i) begin
                r_pipe[0] <= w_raw;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
        end

        assign w_del = r_pipe[PIPE_LAT-1];
    end else begin : g_no_pipe
        assign w_del = w_raw;
    end

    // Output register: applies sync polarity and captures RGB only inside the active area.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_de    <= 1'b0;
            r_hs    <= ~HS_POL;
            r_vs    <= ~VS_POL;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (en_i) begin
            r_de    <= w_del.de;
            r_hs    <= w_del.hs ? HS_POL : ~HS_POL;
            r_vs    <= w_del.vs ? VS_POL : ~VS_POL;
            r_red   <= w_del.de ? red_i   : '0;
            r_green <= w_del.de ? green_i : '0;
            r_blue  <= w_del.de ? blue_i  : '0;
        end
    end

    assign de_o    = r_de;
    assign hsync_o = r_hs;
    assign vsync_o = r_vs;
    assign red_o   = r_red;
    assign green_o = r_green;
    assign blue_o  = r_blue;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-mode instances (pipelined active-low sync,
// and zero-latency active-high sync) checked against a reference raster model
// through per-instance expected-output queues.
module tb_vga_timing_gen;

    // Instance A: 15x8 raster, PIPE_LAT=3, active-low syncs, gated pixel tick.
    localparam int A_HA = 8, A_HF = 2, A_HS = 3, A_HB = 2;
    localparam int A_VA = 4, A_VF = 1, A_VS = 2, A_VB = 1;
    localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
    localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
    localparam int A_LAT = 3;
    localparam int A_W = 6;
    localparam bit A_HP = 1'b0, A_VP = 1'b0;

    // Instance B: 7x5 raster, PIPE_LAT=0, active-high syncs, minimal counter width.
    localparam int B_HA = 4, B_HF = 1, B_HS = 1, B_HB = 1;
    localparam int B_VA = 2, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
    localparam int B_VT = B_VA + B_VF + B_VS + B_VB;
    localparam int B_W = 3;
    localparam bit B_HP = 1'b1, B_VP = 1'b1;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } out_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en_a, en_b;

    logic [3:0] red_a, green_a, blue_a;
    logic       req_a, line_a, frame_a, hs_a, vs_a, de_a;
    logic [A_W-1:0] x_a, y_a;
    logic [3:0] ro_a, go_a, bo_a;

    logic [3:0] red_b, green_b, blue_b;
    logic       req_b, line_b, frame_b, hs_b, vs_b, de_b;
    logic [B_W-1:0] x_b, y_b;
    logic [3:0] ro_b, go_b, bo_b;

    int n_checks = 0;
    int n_errors = 0;

    int ah, av, bh, bv;
    out_t q_a[$];
    out_t q_b[$];
    out_t last_a, last_b;
    logic [11:0] src_a [A_LAT];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .HS_POL(A_HP), .VS_POL(A_VP), .PIPE_LAT(A_LAT), .CNT_W(A_W), .COLOR_W(4)
    ) dut_a (
        .clk_i(clk), .reset_ni(rst_n), .en_i(en_a),
        .red_i(red_a), .green_i(green_a), .blue_i(blue_a),
        .req_o(req_a), .x_o(x_a), .y_o(y_a),
        .line_start_o(line_a), .frame_start_o(frame_a),
        .red_o(ro_a), .green_o(go_a), .blue_o(bo_a),
        .hsync_o(hs_a), .vsync_o(vs_a), .de_o(de_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .HS_POL(B_HP), .VS_POL(B_VP), .PIPE_LAT(0), .CNT_W(B_W), .COLOR_W(4)
    ) dut_b (
        .clk_i(clk), .reset_ni(rst_n), .en_i(en_b),
        .red_i(red_b), .green_i(green_b), .blue_i(blue_b),
        .req_o(req_b), .x_o(x_b), .y_o(y_b),
        .line_start_o(line_b), .frame_start_o(frame_b),
        .red_o(ro_b), .green_o(go_b), .blue_o(bo_b),
        .hsync_o(hs_b), .vsync_o(vs_b), .de_o(de_b)
    );

    // Zero-latency pixel source for instance B: combinational from its coordinates.
    assign red_b   = {1'b0, x_b};
    assign green_b = {1'b0, y_b};
    assign blue_b  = {1'b0, x_b ^ y_b};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pixel value the source delivers for position (h, v).
    function automatic logic [11:0] pix(input int h, input int v);
        return {4'(h), 4'(v), 4'(h ^ v)};
    endfunction

    function automatic out_t exp_out(input int h, input int v,
                                     input int ha, input int hf, input int hsw,
                                     input int va, input int vf, input int vsw,
                                     input bit hp, input bit vp);
        out_t o;
        logic de;
        de   = (h < ha) && (v < va);
        o.de = de;
        o.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
        o.vs = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
        {o.r, o.g, o.b} = de ? pix(h, v) : 12'd0;
        return o;
    endfunction

    function automatic out_t idle_out(input bit hp, input bit vp);
        out_t o;
        o = '0;
        o.hs = ~hp;
        o.vs = ~vp;
        return o;
    endfunction

    function automatic out_t got_a();
        return {de_a, hs_a, vs_a, ro_a, go_a, bo_a};
    endfunction

    function automatic out_t got_b();
        return {de_b, hs_b, vs_b, ro_b, go_b, bo_b};
    endfunction

    // Asynchronous reset at the current time, hold for a few clocks, release at a negedge.
    task automatic do_reset();
        en_a  = 1'b0;
        en_b  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("a_rst_out", 32'(got_a()), 32'(idle_out(A_HP, A_VP)));
        check("b_rst_out", 32'(got_b()), 32'(idle_out(B_HP, B_VP)));
        check("a_rst_xy", 32'({x_a, y_a}), 32'd0);
        check("b_rst_xy", 32'({x_b, y_b}), 32'd0);
        ah = 0; av = 0; bh = 0; bv = 0;
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < A_LAT; i++) begin
            q_a.push_back(idle_out(A_HP, A_VP));
            src_a[i] = 12'd0;
        end
        last_a = idle_out(A_HP, A_VP);
        last_b = idle_out(B_HP, B_VP);
        {red_a, green_a, blue_a} = 12'd0;
        repeat (3) begin
            @(negedge clk);
            en_a = 1'b1;
            en_b = 1'b1;
            #1;
            check("a_rst_hold_x", 32'(x_a), 32'd0);
            check("b_rst_hold_out", 32'(got_b()), 32'(idle_out(B_HP, B_VP)));
        end
        en_a  = 1'b0;
        en_b  = 1'b0;
        rst_n = 1'b1;
    endtask

    // One clock: check combinational outputs against the model, queue the
    // expected registered output per tick, then compare after the edge.
    task automatic do_cycle(input logic ea, input logic eb);
        @(negedge clk);
        en_a = ea;
        en_b = eb;
        #1;
        check("a_x", 32'(x_a), 32'(ah));
        check("a_y", 32'(y_a), 32'(av));
        check("a_req", 32'(req_a), 32'((ah < A_HA) && (av < A_VA)));
        check("a_line", 32'(line_a), 32'(ea && ah == 0));
        check("a_frame", 32'(frame_a), 32'(ea && ah == 0 && av == 0));
        check("b_x", 32'(x_b), 32'(bh));
        check("b_y", 32'(y_b), 32'(bv));
        check("b_req", 32'(req_b), 32'((bh < B_HA) && (bv < B_VA)));
        check("b_line", 32'(line_b), 32'(eb && bh == 0));
        check("b_frame", 32'(frame_b), 32'(eb && bh == 0 && bv == 0));
        if (ea) q_a.push_back(exp_out(ah, av, A_HA, A_HF, A_HS, A_VA, A_VF, A_VS, A_HP, A_VP));
        if (eb) q_b.push_back(exp_out(bh, bv, B_HA, B_HF, B_HS, B_VA, B_VF, B_VS, B_HP, B_VP));
        @(posedge clk);
        #1;
        if (ea) begin
            for (int i = A_LAT - 1; i > 0; i--) src_a[i] = src_a[i-1];
            src_a[0] = pix(ah, av);
            {red_a, green_a, blue_a} = src_a[A_LAT-1];
            if (ah == A_HT - 1) begin
                ah = 0;
                av = (av == A_VT - 1) ? 0 : av + 1;
            end else begin
                ah++;
            end
            if (q_a.size() == 0) check("a_queue_empty", 32'd1, 32'd0);
            else last_a = q_a.pop_front();
        end
        if (eb) begin
            if (bh == B_HT - 1) begin
                bh = 0;
                bv = (bv == B_VT - 1) ? 0 : bv + 1;
            end else begin
                bh++;
            end
            if (q_b.size() == 0) check("b_queue_empty", 32'd1, 32'd0);
            else last_b = q_b.pop_front();
        end
        check("a_out", 32'(got_a()), 32'(last_a));
        check("b_out", 32'(got_b()), 32'(last_b));
    endtask

    initial begin
        en_a  = 1'b0;
        en_b  = 1'b0;
        rst_n = 1'b1;
        {red_a, green_a, blue_a} = 12'd0;
        #3;
        do_reset();

        // Continuous pixel tick: two frames of instance A, many of instance B.
        for (int i = 0; i < 2 * A_HT * A_VT; i++) do_cycle(1'b1, 1'b1);

        // Pixel tick on every second clock for instance A.
        for (int i = 0; i < 4 * A_HT * A_VT; i++) do_cycle(1'((i % 2) == 0), 1'b1);

        // Mid-line reset while instance A is driving active pixels.
        do_reset();
        for (int i = 0; i < 20; i++) do_cycle(1'b1, 1'b1);
        check("a_de_before_rst", 32'(de_a), 32'd1);
        do_reset();

        // Irregular pixel ticks on both instances.
        for (int i = 0; i < 300; i++) do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
